// File: rtl/ofdm_spi_pkg.sv
// Shared types and constants for the OFDM transmitter SPI configuration master.
package ofdm_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // Word size and SCLK divider also used by the transmitter's SPI slave.
  localparam int unsigned SPI_DATA_W_DEF  = 16;
  localparam int unsigned SPI_CLK_DIV_DEF = 4;

  localparam int unsigned MIN_DATA_W  = 2;
  localparam int unsigned MIN_CLK_DIV = 2;
  localparam int unsigned MIN_NSS_CYC = 1;

  function automatic bit spi_params_ok(input int unsigned data_w, input int unsigned clk_div,
                                       input int unsigned nss_setup, input int unsigned nss_hold,
                                       input int unsigned nss_gap);
    return (data_w >= MIN_DATA_W) && (clk_div >= MIN_CLK_DIV) &&
           (nss_setup >= MIN_NSS_CYC) && (nss_hold >= MIN_NSS_CYC) && (nss_gap >= MIN_NSS_CYC);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                      input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ofdm_spi_clkgen.sv
// SCLK half-period timer: counts CLK_DIV cycles per phase while enabled, toggling SCLK at each phase end.
module ofdm_spi_clkgen
  import ofdm_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic phase_end_c,
  output logic sclk
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;

  assign phase_end_c = en && (cnt_q == CNT_W'(CLK_DIV - 1));

  // Disabled outside LOW/HIGH so every transfer starts from a fresh low phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (phase_end_c) begin
      cnt_q <= '0;
      sclk  <= ~sclk;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ofdm_spi_master.sv
// Mode-0, MSB-first SPI master loading one config word per valid/ready command into the transmitter.
module ofdm_spi_master
  import ofdm_spi_pkg::*;
#(
  parameter int unsigned DATA_W    = SPI_DATA_W_DEF,
  parameter int unsigned CLK_DIV   = SPI_CLK_DIV_DEF,
  parameter int unsigned NSS_SETUP = 2,
  parameter int unsigned NSS_HOLD  = 2,
  parameter int unsigned NSS_GAP   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_nss,
  input  logic              spi_miso
);

  localparam int unsigned BIT_W    = $clog2(DATA_W);
  localparam int unsigned WAIT_MAX = max3(NSS_SETUP, NSS_HOLD, NSS_GAP);
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

  if (!spi_params_ok(DATA_W, CLK_DIV, NSS_SETUP, NSS_HOLD, NSS_GAP)) begin : g_bad_params
    $error("ofdm_spi_master: parameter below its minimum value");
  end

  spi_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              rx_valid_d;
  logic              tx_ready_d;
  logic              nss_d;
  logic              clk_en_c;
  logic              phase_end_c;

  assign clk_en_c = (state_q == ST_LOW) || (state_q == ST_HIGH);
  // MOSI is the top bit of the transmit shift register, so it only moves when that register shifts.
  assign spi_mosi = tx_sr_q[DATA_W-1];

  ofdm_spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (clk_en_c),
    .phase_end_c(phase_end_c),
    .sclk       (spi_sclk)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    bit_d      = bit_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    nss_d      = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d = ST_SETUP;
          tx_sr_d = tx_data;
          bit_d   = '0;
          wait_d  = '0;
        end
      end
      ST_SETUP: begin
        if (wait_q == WAIT_W'(NSS_SETUP - 1)) begin
          state_d = ST_LOW;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_LOW: begin
        if (phase_end_c) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        // Sample MISO as late as possible in the high phase.
        if (phase_end_c) begin
          rx_sr_d = {rx_sr_q[DATA_W-2:0], spi_miso};
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOW;
            bit_d   = bit_q + BIT_W'(1);
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (wait_q == WAIT_W'(NSS_HOLD - 1)) begin
          state_d    = ST_GAP;
          wait_d     = '0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_GAP: begin
        if (wait_q == WAIT_W'(NSS_GAP - 1)) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase

    // Registered pin levels follow the state being entered, so they line up with it.
    tx_ready_d = (state_d == ST_IDLE);
    nss_d      = (state_d == ST_IDLE) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      bit_q    <= '0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      spi_nss  <= 1'b1;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      bit_q    <= bit_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      tx_ready <= tx_ready_d;
      busy     <= ~tx_ready_d;
      spi_nss  <= nss_d;
    end
  end

endmodule

// File: tb/tb_ofdm_spi_master.sv
// Bench for ofdm_spi_master: default instance with a mode-0 slave model, plus a DATA_W=8/CLK_DIV=2 instance.
module tb_ofdm_spi_master;

  localparam int DW = 16, CD = 4, SU = 2, HO = 2, GP = 2;
  localparam int NSS_LOW_EXP = SU + 2 * CD * DW + HO;
  localparam int SPACING_EXP = 1 + NSS_LOW_EXP + GP;
  localparam int DWB = 8, CDB = 2;
  localparam int NSS_LOW_B = SU + 2 * CDB * DWB + HO;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [DW-1:0] tx_data_a, rx_data_a;
  logic tx_valid_a, tx_ready_a, rx_valid_a, busy_a, sclk_a, mosi_a, nss_a;
  logic miso_a = 1'b0;
  logic [DWB-1:0] tx_data_b, rx_data_b;
  logic tx_valid_b, tx_ready_b, rx_valid_b, busy_b, sclk_b, mosi_b, nss_b, miso_b;

  ofdm_spi_master #(.DATA_W(DW), .CLK_DIV(CD), .NSS_SETUP(SU), .NSS_HOLD(HO), .NSS_GAP(GP)) dut_a (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
    .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_nss(nss_a), .spi_miso(miso_a));

  ofdm_spi_master #(.DATA_W(DWB), .CLK_DIV(CDB), .NSS_SETUP(SU), .NSS_HOLD(HO), .NSS_GAP(GP)) dut_b (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
    .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_nss(nss_b), .spi_miso(miso_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Slave model and bus observer for instance A
  logic [DW-1:0] slave_word_a = '0, s_tx_a = '0, s_rx_a = '0;
  logic [DW-1:0] slave_q_a[$];
  int acc_q_a[$];
  int low_cnt_a = 0, high_cnt_a = 0, low_last_a = 0, gap_last_a = 0, rise_cnt_a = 0;
  int first_rise_a = 0, bits_a = 0, rxv_cnt_a = 0;
  int viol_mosi_a = 0, viol_busy_a = 0, viol_rxv_a = 0;
  logic nss_prev_a = 1'b1, sclk_prev_a = 1'b0, mosi_prev_a = 1'b0, rdy_prev_a = 1'b0, rst_prev = 1'b0;

  always @(negedge clk) begin
    if (!nss_a) begin
      if (nss_prev_a) begin
        gap_last_a = high_cnt_a; low_cnt_a = 0; bits_a = 0; s_rx_a = '0;
        s_tx_a = slave_word_a; miso_a = s_tx_a[DW-1];
      end
      low_cnt_a++;
      if (sclk_a && !sclk_prev_a) begin
        s_rx_a = {s_rx_a[DW-2:0], mosi_a};
        rise_cnt_a++;
        if (bits_a == 0) first_rise_a = low_cnt_a - 1;
        bits_a++;
      end
      if (!sclk_a && sclk_prev_a) begin
        s_tx_a = s_tx_a << 1; miso_a = s_tx_a[DW-1];
      end
    end else begin
      if (!nss_prev_a) begin
        low_last_a = low_cnt_a; slave_q_a.push_back(s_rx_a); high_cnt_a = 0;
      end
      high_cnt_a++;
    end
    if (mosi_a !== mosi_prev_a && sclk_a) viol_mosi_a++;
    if (rx_valid_a) begin
      rxv_cnt_a++;
      if (!(nss_a && !nss_prev_a)) viol_rxv_a++;
    end
    if (reset_n && rst_prev && (busy_a === tx_ready_a)) viol_busy_a++;
    if (reset_n && rdy_prev_a && !tx_ready_a) acc_q_a.push_back(cyc);
    nss_prev_a = nss_a; sclk_prev_a = sclk_a; mosi_prev_a = mosi_a;
    rdy_prev_a = tx_ready_a; rst_prev = reset_n;
  end

  // Observer for instance B
  logic [DWB-1:0] s_rx_b = '0;
  logic [DWB-1:0] slave_q_b[$];
  int low_cnt_b = 0, low_last_b = 0, rise_cnt_b = 0, bits_b = 0, rise_prev_b = 0;
  int per_min_b = 1000, per_max_b = 0, viol_mosi_b = 0;
  logic nss_prev_b = 1'b1, sclk_prev_b = 1'b0, mosi_prev_b = 1'b0;

  always @(negedge clk) begin
    if (!nss_b) begin
      if (nss_prev_b) begin
        low_cnt_b = 0; bits_b = 0; s_rx_b = '0; per_min_b = 1000; per_max_b = 0;
      end
      low_cnt_b++;
      if (sclk_b && !sclk_prev_b) begin
        s_rx_b = {s_rx_b[DWB-2:0], mosi_b};
        rise_cnt_b++;
        if (bits_b > 0) begin
          if (cyc - rise_prev_b < per_min_b) per_min_b = cyc - rise_prev_b;
          if (cyc - rise_prev_b > per_max_b) per_max_b = cyc - rise_prev_b;
        end
        rise_prev_b = cyc;
        bits_b++;
      end
    end else if (!nss_prev_b) begin
      low_last_b = low_cnt_b; slave_q_b.push_back(s_rx_b);
    end
    if (mosi_b !== mosi_prev_b && sclk_b) viol_mosi_b++;
    nss_prev_b = nss_b; sclk_prev_b = sclk_b; mosi_prev_b = mosi_b;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready_a();
    int i;
    for (i = 0; i < 400 && !tx_ready_a; i++) step();
    if (!tx_ready_a) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ready_a: tx_ready=%b after 400 cycles, required 1", tx_ready_a);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks += 10;
    if (tx_ready_a !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready: got %b exp 0", tx_ready_a); end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy_a); end
    if (rx_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b exp 0", rx_valid_a); end
    if (rx_data_a !== 16'h0) begin n_fail++; $display("FAIL rst_rx_data: got %h exp 0", rx_data_a); end
    if (sclk_a !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b exp 0", sclk_a); end
    if (mosi_a !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b exp 0", mosi_a); end
    if (nss_a !== 1'b1) begin n_fail++; $display("FAIL rst_nss: got %b exp 1", nss_a); end
    if (tx_ready_b !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready_b: got %b exp 0", tx_ready_b); end
    if (nss_b !== 1'b1) begin n_fail++; $display("FAIL rst_nss_b: got %b exp 1", nss_b); end
    if (rx_data_b !== 8'h0) begin n_fail++; $display("FAIL rst_rx_data_b: got %h exp 0", rx_data_b); end
    reset_n = 1'b1;
    step();
    n_checks += 3;
    if (tx_ready_a !== 1'b1) begin n_fail++; $display("FAIL post_rst_tx_ready: got %b exp 1", tx_ready_a); end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy: got %b exp 0", busy_a); end
    if (tx_ready_b !== 1'b1) begin n_fail++; $display("FAIL post_rst_tx_ready_b: got %b exp 1", tx_ready_b); end
  endtask

  task automatic test_single(input logic [DW-1:0] w, input logic [DW-1:0] slv);
    int r0, v0, sq0, i;
    logic [DW-1:0] got;
    r0 = rise_cnt_a; v0 = rxv_cnt_a; sq0 = slave_q_a.size();
    slave_word_a = slv;
    wait_ready_a();
    tx_data_a = w; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    for (i = 0; i < 400 && !rx_valid_a; i++) step();
    n_checks += 7;
    if (!rx_valid_a) begin n_fail++; $display("FAIL single_timeout: rx_valid=%b, required 1", rx_valid_a); end
    if (rx_data_a !== slv) begin n_fail++; $display("FAIL single_rx_data: got %h exp %h", rx_data_a, slv); end
    got = (slave_q_a.size() > sq0) ? slave_q_a[sq0] : 'x;
    if (got !== w) begin n_fail++; $display("FAIL single_slave_word: got %h exp %h", got, w); end
    if (low_last_a != NSS_LOW_EXP) begin n_fail++; $display("FAIL single_nss_low: got %0d exp %0d", low_last_a, NSS_LOW_EXP); end
    if (rise_cnt_a - r0 != DW) begin n_fail++; $display("FAIL single_sclk_rises: got %0d exp %0d", rise_cnt_a - r0, DW); end
    if (first_rise_a != SU + CD) begin n_fail++; $display("FAIL single_first_rise: got %0d exp %0d", first_rise_a, SU + CD); end
    if (nss_a !== 1'b1) begin n_fail++; $display("FAIL single_nss_at_rxv: got %b exp 1", nss_a); end
    step();
    n_checks += 2;
    if (rx_valid_a !== 1'b0) begin n_fail++; $display("FAIL single_rxv_pulse: got %b exp 0", rx_valid_a); end
    if (rxv_cnt_a - v0 != 1) begin n_fail++; $display("FAIL single_rxv_count: got %0d exp 1", rxv_cnt_a - v0); end
  endtask

  task automatic test_back_to_back();
    int a0, sq0, i;
    logic [DW-1:0] w0, w1;
    slave_word_a = DW'($urandom);
    wait_ready_a();
    a0 = acc_q_a.size(); sq0 = slave_q_a.size();
    tx_data_a = 16'h0001; tx_valid_a = 1'b1;
    step();
    tx_data_a = 16'h8000;
    for (i = 0; i < 400; i++) begin
      step();
      if (tx_ready_a) break;
    end
    step();
    tx_valid_a = 1'b0;
    for (i = 0; i < 400 && slave_q_a.size() < sq0 + 2; i++) step();
    repeat (4) step();
    n_checks += 5;
    if (acc_q_a.size() != a0 + 2) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d exp 2", acc_q_a.size() - a0);
    end else if (acc_q_a[a0+1] - acc_q_a[a0] != SPACING_EXP) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d exp %0d", acc_q_a[a0+1] - acc_q_a[a0], SPACING_EXP);
    end
    if (gap_last_a < GP) begin n_fail++; $display("FAIL b2b_nss_gap: got %0d exp >=%0d", gap_last_a, GP); end
    w0 = (slave_q_a.size() > sq0) ? slave_q_a[sq0] : 'x;
    w1 = (slave_q_a.size() > sq0 + 1) ? slave_q_a[sq0+1] : 'x;
    if (w0 !== 16'h0001) begin n_fail++; $display("FAIL b2b_word0: got %h exp 0001", w0); end
    if (w1 !== 16'h8000) begin n_fail++; $display("FAIL b2b_word1: got %h exp 8000", w1); end
    if (tx_ready_a !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: tx_ready=%b exp 1", tx_ready_a); end
  endtask

  task automatic test_busy_ignore();
    int a0, sq0, i;
    logic [DW-1:0] w, got;
    w = DW'($urandom) & 16'h7FFF;
    slave_word_a = DW'($urandom);
    wait_ready_a();
    a0 = acc_q_a.size(); sq0 = slave_q_a.size();
    tx_data_a = w; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    repeat (20) step();
    tx_data_a = 16'hFFFF; tx_valid_a = 1'b1;
    step();
    n_checks++;
    if (tx_ready_a !== 1'b0) begin n_fail++; $display("FAIL busy_tx_ready: got %b exp 0", tx_ready_a); end
    tx_valid_a = 1'b0;
    for (i = 0; i < 400 && slave_q_a.size() < sq0 + 1; i++) step();
    repeat (10) step();
    n_checks += 3;
    if (acc_q_a.size() - a0 != 1) begin n_fail++; $display("FAIL busy_accepts: got %0d exp 1", acc_q_a.size() - a0); end
    got = (slave_q_a.size() > sq0) ? slave_q_a[sq0] : 'x;
    if (got !== w) begin n_fail++; $display("FAIL busy_word: got %h exp %h", got, w); end
    if (nss_a !== 1'b1) begin n_fail++; $display("FAIL busy_nss_idle: got %b exp 1", nss_a); end
  endtask

  task automatic test_reset_mid();
    int r0, v0, i;
    slave_word_a = DW'($urandom);
    r0 = rise_cnt_a; v0 = rxv_cnt_a;
    wait_ready_a();
    tx_data_a = DW'($urandom); tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    for (i = 0; i < 400 && rise_cnt_a < r0 + 7; i++) step();
    n_checks++;
    if (rise_cnt_a != r0 + 7) begin n_fail++; $display("FAIL rmid_reach_bit7: rises=%0d exp 7", rise_cnt_a - r0); end
    reset_n = 1'b0;
    #1;
    n_checks += 3;
    if (nss_a !== 1'b1) begin n_fail++; $display("FAIL rmid_nss_async: got %b exp 1", nss_a); end
    if (sclk_a !== 1'b0) begin n_fail++; $display("FAIL rmid_sclk_async: got %b exp 0", sclk_a); end
    if (tx_ready_a !== 1'b0) begin n_fail++; $display("FAIL rmid_tx_ready: got %b exp 0", tx_ready_a); end
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    n_checks += 2;
    if (rxv_cnt_a != v0) begin n_fail++; $display("FAIL rmid_no_rxv: got %0d pulses exp 0", rxv_cnt_a - v0); end
    if (rx_data_a !== 16'h0) begin n_fail++; $display("FAIL rmid_rx_data: got %h exp 0", rx_data_a); end
    test_single(DW'($urandom), DW'($urandom));
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) step();
      test_single(DW'($urandom), DW'($urandom));
    end
  endtask

  task automatic test_small(input logic [DWB-1:0] w, input logic m);
    int r0, sq0, i;
    logic [DWB-1:0] got, exp_rx;
    exp_rx = m ? 8'hFF : 8'h00;
    miso_b = m;
    r0 = rise_cnt_b; sq0 = slave_q_b.size();
    for (i = 0; i < 200 && !tx_ready_b; i++) step();
    tx_data_b = w; tx_valid_b = 1'b1;
    step();
    tx_valid_b = 1'b0;
    for (i = 0; i < 200 && !rx_valid_b; i++) step();
    n_checks += 7;
    if (rx_data_b !== exp_rx) begin n_fail++; $display("FAIL small_rx_data: got %h exp %h", rx_data_b, exp_rx); end
    got = (slave_q_b.size() > sq0) ? slave_q_b[sq0] : 'x;
    if (got !== w) begin n_fail++; $display("FAIL small_slave_word: got %h exp %h", got, w); end
    if (low_last_b != NSS_LOW_B) begin n_fail++; $display("FAIL small_nss_low: got %0d exp %0d", low_last_b, NSS_LOW_B); end
    if (rise_cnt_b - r0 != DWB) begin n_fail++; $display("FAIL small_rises: got %0d exp %0d", rise_cnt_b - r0, DWB); end
    if (per_min_b != 2 * CDB) begin n_fail++; $display("FAIL small_period_min: got %0d exp %0d", per_min_b, 2 * CDB); end
    if (per_max_b != 2 * CDB) begin n_fail++; $display("FAIL small_period_max: got %0d exp %0d", per_max_b, 2 * CDB); end
    if (viol_mosi_b != 0) begin n_fail++; $display("FAIL small_mosi_stable: %0d changes with sclk high, exp 0", viol_mosi_b); end
    repeat (4) step();
  endtask

  task automatic test_invariants();
    n_checks += 3;
    if (viol_mosi_a != 0) begin n_fail++; $display("FAIL inv_mosi_stable: %0d changes with sclk high, exp 0", viol_mosi_a); end
    if (viol_busy_a != 0) begin n_fail++; $display("FAIL inv_busy_vs_ready: %0d cycles busy==tx_ready, exp 0", viol_busy_a); end
    if (viol_rxv_a != 0) begin n_fail++; $display("FAIL inv_rxv_nss_rise: %0d misaligned pulses, exp 0", viol_rxv_a); end
  endtask

  initial begin
    reset_n = 1'b0;
    tx_valid_a = 1'b0; tx_data_a = '0;
    tx_valid_b = 1'b0; tx_data_b = '0; miso_b = 1'b0;
    test_reset();
    test_single(16'hA5C3, 16'h3C5A);
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_small(8'h5A, 1'b1);
    test_small(DWB'($urandom), 1'b0);
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
